// File: rtl/collision_detect.sv
// collision_detect
//
// Pixel-exact player/obstacle collision detector. During the visible scan it
// counts pixels where both the player sprite and the obstacle layer are opaque,
// and at the end of each full frame it decides whether that frame was a hit
// frame. A run of CONFIRM_FRAMES consecutive hit frames raises a held hit
// request toward the game FSM. The request stays up until the game FSM
// acknowledges it. After that the block locks out further detection until the
// game leaves the running states.
//
// Ports:
//   CLK          system clock
//   RESET_N      asynchronous active-low reset
//   pix_en       pixel strobe; hc/vc/pixel inputs are valid when high
//   hc, vc       horizontal / vertical beam counters
//   state        game FSM state; 4'h5..4'hA are the running states
//   player_pix   player sprite colour index, 0 = transparent
//   obstacle_pix obstacle colour index, 0 = transparent
//   hit_ack      game FSM acknowledge of hit (only honoured while in HIT)
//   hit          collision request, held until acknowledged
//   hit_x, hit_y position of the first overlapping pixel of the confirming frame
//   overlap_cnt  overlap pixel count of the last evaluated frame
//   busy         high whenever the detector FSM is not IDLE

module collision_detect #(
    parameter int unsigned CIDXW          = 3,
    parameter int unsigned CORDW          = 10,
    parameter int unsigned HIT_THRESH     = 4,
    parameter int unsigned CONFIRM_FRAMES = 2,
    parameter int unsigned H_START        = 143,
    parameter int unsigned H_END          = 784,
    parameter int unsigned V_START        = 34,
    parameter int unsigned V_END          = 516
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             pix_en,
    input  logic [CORDW-1:0] hc,
    input  logic [CORDW-1:0] vc,
    input  logic [3:0]       state,
    input  logic [CIDXW:0]   player_pix,
    input  logic [CIDXW:0]   obstacle_pix,
    input  logic             hit_ack,
    output logic             hit,
    output logic [CORDW-1:0] hit_x,
    output logic [CORDW-1:0] hit_y,
    output logic [15:0]      overlap_cnt,
    output logic             busy
);

    localparam logic [CORDW-1:0] HStart        = CORDW'(H_START);
    localparam logic [CORDW-1:0] HEnd          = CORDW'(H_END);
    localparam logic [CORDW-1:0] VStart        = CORDW'(V_START);
    localparam logic [CORDW-1:0] VEnd          = CORDW'(V_END);
    localparam logic [15:0]      HitThresh     = 16'(HIT_THRESH);
    localparam logic [4:0]       ConfirmFrames = 5'(CONFIRM_FRAMES);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StEval,
        StHit,
        StLock
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [CORDW-1:0] first_x_q, first_x_d;
    logic [CORDW-1:0] first_y_q, first_y_d;
    logic [3:0]       confirm_q, confirm_d;
    logic             hit_q, hit_d;
    logic [CORDW-1:0] hit_x_q, hit_x_d;
    logic [CORDW-1:0] hit_y_q, hit_y_d;
    logic [15:0]      ovl_cnt_q, ovl_cnt_d;
    logic             busy_q, busy_d;

    // Decoded per-pixel conditions
    logic        running;
    logic        frame_start;
    logic        frame_end;
    logic        in_visible;
    logic        overlap;
    logic [15:0] cnt_inc;
    logic [4:0]  confirm_inc;
    logic        thresh_met;

    always_comb begin
        running     = (state >= 4'h5) && (state <= 4'hA);
        frame_start = pix_en && (hc == '0) && (vc == '0);
        frame_end   = pix_en && (hc == HEnd) && (vc == VEnd);
        in_visible  = (hc >= HStart) && (hc <= HEnd) && (vc >= VStart) && (vc <= VEnd);
        overlap     = pix_en && in_visible && (|player_pix) && (|obstacle_pix);
        // Saturate rather than wrap so a huge overlap never looks like a small one.
        cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        // One bit wider so the compare against CONFIRM_FRAMES (up to 15) cannot alias.
        confirm_inc = {1'b0, confirm_q} + 5'd1;
        thresh_met  = (cnt_q >= HitThresh);
    end

    // Next-state and datapath updates
    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        first_x_d = first_x_q;
        first_y_d = first_y_q;
        confirm_d = confirm_q;
        hit_d     = hit_q;
        hit_x_d   = hit_x_q;
        hit_y_d   = hit_y_q;
        ovl_cnt_d = ovl_cnt_q;

        unique case (fsm_q)
            StIdle: begin
                cnt_d     = '0;
                first_d   = 1'b0;
                confirm_d = '0;
                // Only enter on a frame boundary so partial frames are never scanned.
                if (frame_start && running) begin
                    fsm_d = StScan;
                end
            end

            StScan: begin
                if (!running) begin
                    fsm_d     = StIdle;
                    cnt_d     = '0;
                    first_d   = 1'b0;
                    confirm_d = '0;
                end else begin
                    if (overlap) begin
                        cnt_d = cnt_inc;
                        if (!first_q) begin
                            first_d   = 1'b1;
                            first_x_d = hc;
                            first_y_d = vc;
                        end
                    end
                    // The last visible pixel is still counted above before evaluating.
                    if (frame_end) begin
                        fsm_d = StEval;
                    end
                end
            end

            StEval: begin
                ovl_cnt_d = cnt_q;
                confirm_d = thresh_met ? confirm_inc[3:0] : 4'd0;
                if (thresh_met && (confirm_inc == ConfirmFrames)) begin
                    hit_x_d = first_x_q;
                    hit_y_d = first_y_q;
                    hit_d   = 1'b1;
                    fsm_d   = StHit;
                end else begin
                    fsm_d = StScan;
                end
                cnt_d   = '0;
                first_d = 1'b0;
            end

            StHit: begin
                // Held regardless of the game state until explicitly acknowledged.
                if (hit_ack) begin
                    hit_d = 1'b0;
                    fsm_d = StLock;
                end
            end

            StLock: begin
                // Wait for the game to leave the running states so one collision
                // event produces exactly one hit.
                if (!running) begin
                    fsm_d     = StIdle;
                    confirm_d = '0;
                end
            end

            default: begin
                fsm_d = StIdle;
            end
        endcase

        busy_d = (fsm_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fsm_q     <= StIdle;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            first_x_q <= '0;
            first_y_q <= '0;
            confirm_q <= '0;
            hit_q     <= 1'b0;
            hit_x_q   <= '0;
            hit_y_q   <= '0;
            ovl_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            first_x_q <= first_x_d;
            first_y_q <= first_y_d;
            confirm_q <= confirm_d;
            hit_q     <= hit_d;
            hit_x_q   <= hit_x_d;
            hit_y_q   <= hit_y_d;
            ovl_cnt_q <= ovl_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign hit         = hit_q;
    assign hit_x       = hit_x_q;
    assign hit_y       = hit_y_q;
    assign overlap_cnt = ovl_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_collision_detect.sv
// Testbench for collision_detect. Stimulus drives sparse pixel sequences
// (frame start, chosen overlap pixels, frame end) and pushes hand-computed
// expectations, stamped with the cycle on which they must hold, into a
// scoreboard queue. An independent monitor pops and compares them. It also
// cross-checks every rising edge of hit against an expected one.

module tb_collision_detect;

    logic       CLK;
    logic       RESET_N;
    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [3:0] state;
    logic [3:0] player_pix;
    logic [3:0] obstacle_pix;
    logic       hit_ack;
    logic       hit;
    logic [9:0] hit_x;
    logic [9:0] hit_y;
    logic [15:0] overlap_cnt;
    logic       busy;

    collision_detect dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .pix_en       (pix_en),
        .hc           (hc),
        .vc           (vc),
        .state        (state),
        .player_pix   (player_pix),
        .obstacle_pix (obstacle_pix),
        .hit_ack      (hit_ack),
        .hit          (hit),
        .hit_x        (hit_x),
        .hit_y        (hit_y),
        .overlap_cnt  (overlap_cnt),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        int          due;
        logic [15:0] cnt;
        logic        hit;
        logic [9:0]  hx;
        logic [9:0]  hy;
        logic        busy;
        logic        rise;
    } exp_t;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [3:0] pp;
        logic [3:0] op;
    } pix_t;

    exp_t sb[$];
    pix_t fq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void push(input string nm, input int due, input logic [15:0] c,
                                 input logic h, input logic [9:0] x, input logic [9:0] y,
                                 input logic b, input logic r);
        exp_t e;
        e.nm = nm; e.due = due; e.cnt = c; e.hit = h;
        e.hx = x; e.hy = y; e.busy = b; e.rise = r;
        sb.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s: got %0d want %0d (cycle %0d)", nm, fld, act, want, cyc);
        end
    endtask

    logic hit_prev = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        logic rise_exp;
        logic rise_seen;
        rise_exp = 1'b0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s.slot: got cycle %0d want %0d", e.nm, cyc, e.due);
            end else begin
                chk(e.nm, "hit", {15'd0, hit}, {15'd0, e.hit});
                chk(e.nm, "hit_x", {6'd0, hit_x}, {6'd0, e.hx});
                chk(e.nm, "hit_y", {6'd0, hit_y}, {6'd0, e.hy});
                chk(e.nm, "overlap_cnt", overlap_cnt, e.cnt);
                chk(e.nm, "busy", {15'd0, busy}, {15'd0, e.busy});
                if (e.rise) rise_exp = 1'b1;
            end
        end
        rise_seen = hit && !hit_prev;
        if (rise_seen || rise_exp) begin
            chk("hit_edge", "rise", {15'd0, rise_seen}, {15'd0, rise_exp});
        end
        hit_prev = hit;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v,
                         input logic [3:0] p, input logic [3:0] o);
        pix_en       = 1'b1;
        hc           = h;
        vc           = v;
        player_pix   = p;
        obstacle_pix = o;
        @(posedge CLK);
        #1;
        pix_en       = 1'b0;
        player_pix   = '0;
        obstacle_pix = '0;
    endtask

    function automatic void add_px(input logic [9:0] h, input logic [9:0] v,
                                   input logic [3:0] p, input logic [3:0] o);
        pix_t px;
        px.h = h; px.v = v; px.pp = p; px.op = o;
        fq.push_back(px);
    endfunction

    function automatic void add_ovl(input logic [9:0] h, input logic [9:0] v, input int n);
        for (int i = 0; i < n; i++) add_px(h + 10'(i), v, 4'h3, 4'h8);
    endfunction

    // Full frame: start pixel, queued pixels, end pixel; expectation lands one
    // cycle after the evaluation cycle that follows frame_end.
    task automatic run_frame(input string nm, input bit end_ovl, input logic [15:0] c,
                             input logic h, input logic [9:0] x, input logic [9:0] y,
                             input logic b, input logic r);
        drive(10'd0, 10'd0, 4'h0, 4'h0);
        foreach (fq[i]) drive(fq[i].h, fq[i].v, fq[i].pp, fq[i].op);
        drive(10'd784, 10'd516, end_ovl ? 4'h3 : 4'h0, end_ovl ? 4'h8 : 4'h0);
        push(nm, cyc + 1, c, h, x, y, b, r);
        fq.delete();
        idle(4);
    endtask

    task automatic pulse_ack();
        hit_ack = 1'b1;
        @(posedge CLK);
        #1;
        hit_ack = 1'b0;
    endtask

    task automatic outside_frame_pixels();
        add_ovl(10'd142, 10'd250, 1);
        add_ovl(10'd400, 10'd517, 1);
        add_ovl(10'd400, 10'd33, 1);
        add_ovl(10'd785, 10'd250, 1);
        add_px(10'd410, 10'd250, 4'h0, 4'h8);
        add_px(10'd411, 10'd250, 4'h3, 4'h0);
    endtask

    task automatic boundary_frame_pixels();
        add_ovl(10'd143, 10'd34, 1);
        add_ovl(10'd784, 10'd34, 1);
        add_ovl(10'd143, 10'd516, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        RESET_N = 1'b0; pix_en = 1'b0; hc = '0; vc = '0; state = 4'h0;
        player_pix = '0; obstacle_pix = '0; hit_ack = 1'b0;
        idle(3);
        push("reset", cyc, 16'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
        idle(1);
        RESET_N = 1'b1;
        idle(2);

        // Two qualifying frames at (400,250)
        state = 4'h5;
        add_ovl(10'd400, 10'd250, 5);
        run_frame("qual_f1", 1'b0, 16'd5, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0);
        add_ovl(10'd400, 10'd250, 5);
        run_frame("qual_f2", 1'b0, 16'd5, 1'b1, 10'd400, 10'd250, 1'b1, 1'b1);

        // Hit held without ack while the game moves on
        state = 4'h3;
        idle(100);
        push("hold", cyc, 16'd5, 1'b1, 10'd400, 10'd250, 1'b1, 1'b0);
        idle(1);
        state = 4'h5;
        pulse_ack();
        push("ack", cyc, 16'd5, 1'b0, 10'd400, 10'd250, 1'b1, 1'b0);
        idle(1);
        add_ovl(10'd400, 10'd250, 8);
        run_frame("lock_frame", 1'b0, 16'd5, 1'b0, 10'd400, 10'd250, 1'b1, 1'b0);
        state = 4'hB;
        idle(1);
        push("lock_exit", cyc, 16'd5, 1'b0, 10'd400, 10'd250, 1'b0, 1'b0);
        idle(2);

        // 5,3,5,5 overlaps: confirm breaks on frame 2
        state = 4'h5;
        add_ovl(10'd200, 10'd300, 5);
        run_frame("seq_f1", 1'b0, 16'd5, 1'b0, 10'd400, 10'd250, 1'b1, 1'b0);
        add_ovl(10'd200, 10'd300, 3);
        run_frame("seq_f2", 1'b0, 16'd3, 1'b0, 10'd400, 10'd250, 1'b1, 1'b0);
        add_ovl(10'd200, 10'd300, 5);
        run_frame("seq_f3", 1'b0, 16'd5, 1'b0, 10'd400, 10'd250, 1'b1, 1'b0);
        add_ovl(10'd300, 10'd100, 5);
        run_frame("seq_f4", 1'b0, 16'd5, 1'b1, 10'd300, 10'd100, 1'b1, 1'b1);
        pulse_ack();
        push("seq_ack", cyc, 16'd5, 1'b0, 10'd300, 10'd100, 1'b1, 1'b0);
        state = 4'hB;
        idle(1);
        push("seq_idle", cyc, 16'd5, 1'b0, 10'd300, 10'd100, 1'b0, 1'b0);
        idle(2);

        // Visible-window edges and transparency
        state = 4'h5;
        outside_frame_pixels();
        run_frame("outside_1", 1'b0, 16'd0, 1'b0, 10'd300, 10'd100, 1'b1, 1'b0);
        boundary_frame_pixels();
        run_frame("edges_1", 1'b1, 16'd4, 1'b0, 10'd300, 10'd100, 1'b1, 1'b0);
        outside_frame_pixels();
        run_frame("outside_2", 1'b0, 16'd0, 1'b0, 10'd300, 10'd100, 1'b1, 1'b0);
        boundary_frame_pixels();
        run_frame("edges_2", 1'b1, 16'd4, 1'b0, 10'd300, 10'd100, 1'b1, 1'b0);
        state = 4'hB;
        idle(1);
        push("scan_abort", cyc, 16'd4, 1'b0, 10'd300, 10'd100, 1'b0, 1'b0);
        idle(2);

        // Running raised mid-frame: the partial frame is ignored
        state = 4'h5;
        drive(10'd400, 10'd200, 4'h3, 4'h8);
        drive(10'd401, 10'd200, 4'h3, 4'h8);
        drive(10'd402, 10'd200, 4'h3, 4'h8);
        drive(10'd784, 10'd516, 4'h3, 4'h8);
        idle(1);
        push("partial", cyc, 16'd4, 1'b0, 10'd300, 10'd100, 1'b0, 1'b0);
        idle(2);
        add_ovl(10'd500, 10'd400, 5);
        run_frame("full_after", 1'b0, 16'd5, 1'b0, 10'd300, 10'd100, 1'b1, 1'b0);

        // Reset mid-scan with 3 overlaps counted
        drive(10'd0, 10'd0, 4'h0, 4'h0);
        drive(10'd500, 10'd400, 4'h3, 4'h8);
        drive(10'd501, 10'd400, 4'h3, 4'h8);
        drive(10'd502, 10'd400, 4'h3, 4'h8);
        #2;
        RESET_N = 1'b0;
        push("mid_reset", cyc, 16'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
        idle(2);
        RESET_N = 1'b1;
        idle(1);
        push("after_reset", cyc, 16'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
        idle(2);
        add_ovl(10'd250, 10'd260, 5);
        run_frame("requal_f1", 1'b0, 16'd5, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0);
        add_ovl(10'd260, 10'd270, 5);
        run_frame("requal_f2", 1'b0, 16'd5, 1'b1, 10'd260, 10'd270, 1'b1, 1'b1);
        pulse_ack();
        state = 4'hB;
        idle(1);
        push("final", cyc, 16'd5, 1'b0, 10'd260, 10'd270, 1'b0, 1'b0);
        idle(4);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
